// File: rtl/bsg_credit_pkt_sched_pkg.sv
// Purpose: shared types and helpers for the credit packet scheduler.
//   state_e  : scheduler FSM state (idle arbitration / packet lock)
//   rot_idx  : rotate-priority index, (base + off) mod n
package bsg_credit_pkt_sched_pkg;

  typedef enum logic [0:0] {
    e_idle = 1'b0,
    e_lock = 1'b1
  } state_e;

  // Index of the requester 'off' positions above 'base', wrapping at n.
  function automatic int unsigned rot_idx(input int unsigned base,
                                          input int unsigned off,
                                          input int unsigned n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/bsg_credit_pkt_sched_rr_picker.sv
// Purpose: combinational rotating-priority picker.
// Ports:
//   req_i     in   num_req_p  request vector
//   rr_ptr_i  in   lg_req_lp  highest-priority index this cycle
//   found_o   out  1          some request is set
//   winner_o  out  lg_req_lp  first set request at or above rr_ptr_i (wrapping)
module bsg_credit_pkt_sched_rr_picker
  import bsg_credit_pkt_sched_pkg::*;
#(
  parameter  int unsigned num_req_p = 4,
  localparam int unsigned lg_req_lp = $clog2(num_req_p)
) (
  input  logic [num_req_p-1:0] req_i,
  input  logic [lg_req_lp-1:0] rr_ptr_i,
  output logic                 found_o,
  output logic [lg_req_lp-1:0] winner_o
);

  logic [lg_req_lp-1:0] idx;

  // Scan from the farthest offset down so the nearest request wins last.
  always_comb begin
    found_o  = 1'b0;
    winner_o = '0;
    idx      = '0;
    for (int off = int'(num_req_p) - 1; off >= 0; off--) begin
      idx = lg_req_lp'(rot_idx(32'(rr_ptr_i), unsigned'(off), num_req_p));
      if (req_i[idx]) begin
        found_o  = 1'b1;
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/bsg_credit_pkt_sched.sv
// Purpose: shares one downstream credit pool among num_req_p requesters with
// packet-granular round-robin arbitration; each accepted beat spends a credit.
// Ports:
//   clk_i            in   1            clock
//   reset_i          in   1            synchronous active-high reset
//   v_i              in   num_req_p    per-requester beat valid
//   last_i           in   num_req_p    per-requester last beat of packet
//   yumi_o           out  num_req_p    one-hot beat accept (combinational)
//   grant_id_o       out  lg_req_lp    accepted requester index (combinational)
//   credit_return_i  in   1            one credit returned this cycle
//   credits_o        out  credit_w_lp  registered pool count
//   locked_o         out  1            packet in progress
//   owner_o          out  lg_req_lp    current packet owner
module bsg_credit_pkt_sched
  import bsg_credit_pkt_sched_pkg::*;
#(
  parameter  int unsigned num_req_p   = 4,
  parameter  int unsigned credits_p   = 8,
  localparam int unsigned lg_req_lp   = $clog2(num_req_p),
  localparam int unsigned credit_w_lp = $clog2(credits_p + 1)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [num_req_p-1:0]   v_i,
  input  logic [num_req_p-1:0]   last_i,
  output logic [num_req_p-1:0]   yumi_o,
  output logic [lg_req_lp-1:0]   grant_id_o,
  input  logic                   credit_return_i,
  output logic [credit_w_lp-1:0] credits_o,
  output logic                   locked_o,
  output logic [lg_req_lp-1:0]   owner_o
);

  localparam logic [credit_w_lp-1:0] credits_max_lp = credit_w_lp'(credits_p);

  state_e                 state_r, state_n;
  logic [lg_req_lp-1:0]   rr_ptr_r, rr_ptr_n;
  logic [lg_req_lp-1:0]   owner_r, owner_n;
  logic [credit_w_lp-1:0] count_r, count_n;

  logic                   pick_found;
  logic [lg_req_lp-1:0]   pick_winner;
  logic                   has_credit;
  logic                   accept;

  function automatic logic [lg_req_lp-1:0] next_ptr(input logic [lg_req_lp-1:0] p);
    return lg_req_lp'(rot_idx(32'(p), 32'd1, num_req_p));
  endfunction

  bsg_credit_pkt_sched_rr_picker #(
    .num_req_p (num_req_p)
  ) picker (
    .req_i    (v_i),
    .rr_ptr_i (rr_ptr_r),
    .found_o  (pick_found),
    .winner_o (pick_winner)
  );

  // Only the registered count gates acceptance; returns are not bypassed.
  assign has_credit = (count_r != '0);

  // Next-state and accept logic.
  always_comb begin
    state_n    = state_r;
    rr_ptr_n   = rr_ptr_r;
    owner_n    = owner_r;
    yumi_o     = '0;
    grant_id_o = '0;
    accept     = 1'b0;
    case (state_r)
      e_idle: begin
        if (pick_found && has_credit && !reset_i) begin
          yumi_o[pick_winner] = 1'b1;
          grant_id_o          = pick_winner;
          accept              = 1'b1;
          if (last_i[pick_winner]) begin
            rr_ptr_n = next_ptr(pick_winner);
          end else begin
            state_n = e_lock;
            owner_n = pick_winner;
          end
        end
      end
      e_lock: begin
        // Everyone but the owner is ignored until its last beat is accepted.
        if (v_i[owner_r] && has_credit && !reset_i) begin
          yumi_o[owner_r] = 1'b1;
          grant_id_o      = owner_r;
          accept          = 1'b1;
          if (last_i[owner_r]) begin
            state_n  = e_idle;
            rr_ptr_n = next_ptr(owner_r);
          end
        end
      end
      default: state_n = e_idle;
    endcase
  end

  // Credit pool: a return and a consume in the same cycle cancel out.
  always_comb begin
    count_n = count_r;
    if (credit_return_i && !accept) begin
      count_n = (count_r == credits_max_lp) ? credits_max_lp
                                            : count_r + credit_w_lp'(1);
    end else if (!credit_return_i && accept) begin
      count_n = count_r - credit_w_lp'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r  <= e_idle;
      rr_ptr_r <= '0;
      owner_r  <= '0;
      count_r  <= credits_max_lp;
    end else begin
      state_r  <= state_n;
      rr_ptr_r <= rr_ptr_n;
      owner_r  <= owner_n;
      count_r  <= count_n;
    end
  end

  assign credits_o = count_r;
  assign locked_o  = (state_r == e_lock);
  assign owner_o   = owner_r;

  // Returning a credit into a full pool is a protocol error upstream.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
    !(credit_return_i && !accept && (count_r == credits_max_lp)));

  a_yumi_onehot: assert property (@(posedge clk_i) disable iff (reset_i)
    $onehot0(yumi_o));

  a_yumi_has_v: assert property (@(posedge clk_i) disable iff (reset_i)
    ((yumi_o & ~v_i) == '0));

endmodule
